// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset pulse, lock qualification and system reset release.
// `define PLL_RST_SEQ_RETRY_EN builds the lock timeout / PLL retry loop.
module pll_rst_seq #(
    parameter int unsigned PLL_RST_CYC      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 270000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned RST_HOLD_CYC     = 64
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       locked,
    output logic [2:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] lost_cnt
);

    localparam int unsigned CNT_MAX = 32'd1048575;

    if (PLL_RST_CYC == 0 || PLL_RST_CYC > CNT_MAX ||
        LOCK_TIMEOUT_CYC == 0 || LOCK_TIMEOUT_CYC > CNT_MAX ||
        LOCK_STABLE_CYC == 0 || LOCK_STABLE_CYC > CNT_MAX ||
        RST_HOLD_CYC == 0 || RST_HOLD_CYC > CNT_MAX) begin : g_bad_param
        $error("pll_rst_seq: cycle counts must lie in 1..2^20-1");
    end

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam logic [19:0] RST_LAST  = 20'(PLL_RST_CYC - 1);
    localparam logic [19:0] STB_LAST  = 20'(LOCK_STABLE_CYC - 1);
    localparam logic [19:0] HOLD_LAST = 20'(RST_HOLD_CYC - 1);

    state_t      st;
    state_t      st_nxt;
    logic [19:0] cnt;
    logic [1:0]  sync_q;
    logic        lock_s;
    logic        cnt_run;
    logic        lost_evt;

`ifdef PLL_RST_SEQ_RETRY_EN
    localparam logic [19:0] TO_LAST = 20'(LOCK_TIMEOUT_CYC - 1);
    logic timeout_evt;
`endif

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    assign lock_s = sync_q[1];

    // Loss of lock is checked before any count expiry in every state.
    always_comb begin
        st_nxt   = st;
        cnt_run  = 1'b0;
        lost_evt = 1'b0;
`ifdef PLL_RST_SEQ_RETRY_EN
        timeout_evt = 1'b0;
`endif
        unique case (st)
            PLL_RST: begin
                cnt_run = 1'b1;
                if (cnt == RST_LAST) st_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) st_nxt = STABLE;
`ifdef PLL_RST_SEQ_RETRY_EN
                else if (cnt == TO_LAST) begin
                    st_nxt      = PLL_RST;
                    timeout_evt = 1'b1;
                end
                cnt_run = 1'b1;
`endif
            end
            STABLE: begin
                cnt_run = 1'b1;
                if (!lock_s) st_nxt = WAIT_LOCK;
                else if (cnt == STB_LAST) st_nxt = HOLD;
            end
            HOLD: begin
                cnt_run = 1'b1;
                if (!lock_s) st_nxt = PLL_RST;
                else if (cnt == HOLD_LAST) st_nxt = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    st_nxt   = PLL_RST;
                    lost_evt = 1'b1;
                end
            end
            default: st_nxt = PLL_RST;
        endcase
    end

    // Outputs are flopped from the next state so they change with state.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            st        <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            locked    <= 1'b0;
            lost_cnt  <= '0;
        end else begin
            st <= st_nxt;
            if (st_nxt != st) cnt <= '0;
            else if (cnt_run) cnt <= cnt + 20'd1;
            pll_reset <= (st_nxt == PLL_RST);
            sys_rst   <= (st_nxt != RUN);
            locked    <= (st_nxt == RUN);
            if (lost_evt && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
        end
    end

`ifdef PLL_RST_SEQ_RETRY_EN
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if (timeout_evt && retry_cnt != 8'hFF) begin
            retry_cnt <= retry_cnt + 8'd1;
        end
    end
`else
    assign retry_cnt = 8'd0;
`endif

    assign state = st;

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed vectors for pll_rst_seq with short cycle counts.
// Retry scenarios run only when PLL_RST_SEQ_RETRY_EN is defined.
module tb_pll_rst_seq;

    logic       clkin    = 1'b0;
    logic       reset    = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       sys_rst;
    logic       locked;
    logic [2:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] lost_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pll_rst_seq #(
        .PLL_RST_CYC     (4),
        .LOCK_TIMEOUT_CYC(32),
        .LOCK_STABLE_CYC (8),
        .RST_HOLD_CYC    (4)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_rst  (sys_rst),
        .locked   (locked),
        .state    (state),
        .retry_cnt(retry_cnt),
        .lost_cnt (lost_cnt)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        int         n;
        logic       lock;
        logic       pr;
        logic       sr;
        logic       lk;
        logic [2:0] st;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_outs(input string name, input logic pr, input logic sr,
                            input logic lk, input logic [2:0] st);
        chk({name, ".pll_reset"}, int'(pll_reset), int'(pr));
        chk({name, ".sys_rst"}, int'(sys_rst), int'(sr));
        chk({name, ".locked"}, int'(locked), int'(lk));
        chk({name, ".state"}, int'(state), int'(st));
    endtask

    task automatic chk_reset_vals(input string name);
        chk_outs(name, 1'b1, 1'b1, 1'b0, 3'd0);
        chk({name, ".retry_cnt"}, int'(retry_cnt), 0);
        chk({name, ".lost_cnt"}, int'(lost_cnt), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pll_lock = 1'b0;
        #2;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int highs;

        tbl[0]  = '{3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[1]  = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[2]  = '{6, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[3]  = '{2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[4]  = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2};
        tbl[5]  = '{7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2};
        tbl[6]  = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
        tbl[7]  = '{3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
        tbl[8]  = '{1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
        tbl[9]  = '{5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
        tbl[10] = '{2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4};
        tbl[11] = '{1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[12] = '{3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[13] = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[14] = '{2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[15] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2};
        tbl[16] = '{8, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
        tbl[17] = '{3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
        tbl[18] = '{1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};

        #1 reset = 1'b1;
        #1 chk_reset_vals("por");
        tick();
        reset = 1'b0;

        // Happy path, loss of lock in RUN, relock.
        for (int i = 0; i < NV; i++) begin
            pll_lock = tbl[i].lock;
            repeat (tbl[i].n) tick();
            chk_outs($sformatf("v%0d", i), tbl[i].pr, tbl[i].sr,
                     tbl[i].lk, tbl[i].st);
        end
        chk("relock.lost_cnt", int'(lost_cnt), 1);
        chk("relock.retry_cnt", int'(retry_cnt), 0);

        // Second loss, then async reset in the middle of HOLD.
        pll_lock = 1'b0;
        repeat (3) tick();
        chk("loss2.state", int'(state), 0);
        chk("loss2.lost_cnt", int'(lost_cnt), 2);
        pll_lock = 1'b1;
        repeat (15) tick();
        chk("midhold.state", int'(state), 3);
        reset = 1'b1;
        #2;
        chk_reset_vals("async");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk_outs("rel3", 1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        chk_outs("rel4", 1'b0, 1'b1, 1'b0, 3'd1);
        tick();
        chk("rel5.state", int'(state), 2);

        // One-cycle lock glitch late in STABLE.
        do_reset();
        repeat (4) tick();
        pll_lock = 1'b1;
        repeat (8) tick();
        chk("glitch.cnt5.state", int'(state), 2);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        chk("glitch.e14.state", int'(state), 2);
        tick();
        chk("glitch.drop.state", int'(state), 1);
        tick();
        chk("glitch.back.state", int'(state), 2);
        repeat (7) tick();
        chk("glitch.win7.state", int'(state), 2);
        tick();
        chk("glitch.hold.state", int'(state), 3);
        chk("glitch.retry_cnt", int'(retry_cnt), 0);

`ifdef PLL_RST_SEQ_RETRY_EN
        // Lock arriving on the timeout cycle wins.
        do_reset();
        repeat (33) tick();
        pll_lock = 1'b1;
        repeat (2) tick();
        chk("coinc.pre.state", int'(state), 1);
        tick();
        chk("coinc.state", int'(state), 2);
        chk("coinc.retry_cnt", int'(retry_cnt), 0);

        // No lock: periodic PLL reset and saturating retry count.
        do_reset();
        repeat (35) tick();
        chk_outs("to.pre", 1'b0, 1'b1, 1'b0, 3'd1);
        chk("to.pre.retry", int'(retry_cnt), 0);
        tick();
        chk_outs("to1", 1'b1, 1'b1, 1'b0, 3'd0);
        chk("to1.retry", int'(retry_cnt), 1);
        repeat (3) tick();
        chk("to1.pulse3.pll_reset", int'(pll_reset), 1);
        tick();
        chk("to1.pulse4.pll_reset", int'(pll_reset), 0);
        repeat (32) tick();
        chk("to2.pll_reset", int'(pll_reset), 1);
        chk("to2.retry", int'(retry_cnt), 2);
        repeat (36) tick();
        chk("to3.retry", int'(retry_cnt), 3);
        repeat (36 * 260) tick();
        chk("to.sat.retry", int'(retry_cnt), 255);
`else
        // No timeout: WAIT_LOCK forever after the first pulse.
        do_reset();
        repeat (4) tick();
        highs = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (pll_reset) highs++;
        end
        chk("noretry.pll_reset_highs", highs, 0);
        chk("noretry.state", int'(state), 1);
        chk("noretry.retry_cnt", int'(retry_cnt), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameters, one per line: name, default, meaning; all counts are clkin cycles, each SHALL be in 1..2^20-1.
- PLL_RST_CYC, 16, PLL reset pulse width.
- LOCK_TIMEOUT_CYC, 270000, maximum wait for lock (10 ms at 27 MHz).
- LOCK_STABLE_CYC, 1024, consecutive lock cycles required before lock is accepted.
- RST_HOLD_CYC, 64, system reset extension after lock is accepted.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clkin, in, 1, 27 MHz reference clock; the only clock.
- reset, in, 1, asynchronous active-high reset.
- pll_lock, in, 1, PLL lock indicator; asynchronous to clkin.
- pll_reset, out, 1, drives the PLL RESET input.
- sys_rst, out, 1, active-high system reset for logic clocked from the PLL output.
- locked, out, 1, high only in RUN.
- state, out, 3, current FSM state code.
- retry_cnt, out, 8, saturating count of lock timeouts.
- lost_cnt, out, 8, saturating count of lock losses while in RUN.

Function
REQ-003 pll_lock SHALL pass through a 2-flop synchronizer to lock_s; no other logic SHALL use pll_lock.
REQ-004 FSM state codes SHALL be PLL_RST=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4. One 20-bit counter cnt SHALL clear on every state change.
REQ-005 PLL_RST: pll_reset=1 and sys_rst=1. After PLL_RST_CYC cycles, go to WAIT_LOCK.
REQ-006 WAIT_LOCK: pll_reset=0 and sys_rst=1.
- lock_s=1: go to STABLE.
- Otherwise at cnt==LOCK_TIMEOUT_CYC-1: go to PLL_RST and increment retry_cnt.
- If lock_s=1 and timeout coincide in the same cycle, lock wins.
REQ-007 STABLE: sys_rst=1.
- lock_s=0: go to WAIT_LOCK; the timeout restarts from 0.
- lock_s held for LOCK_STABLE_CYC cycles: go to HOLD.
REQ-008 HOLD: sys_rst=1.
- lock_s=0: go to PLL_RST.
- After RST_HOLD_CYC cycles: go to RUN.
REQ-009 RUN: sys_rst=0 and locked=1.
- lock_s=0: go to PLL_RST and increment lost_cnt.
- sys_rst reasserts on the same edge as the transition, 3 edges after pll_lock falls.
REQ-010 All outputs SHALL be registered and glitch-free. pll_reset, sys_rst and locked SHALL be decoded from the registered state.
REQ-011 retry_cnt and lost_cnt SHALL saturate at 255 and clear only on reset.
REQ-012 Happy-path latency: sys_rst SHALL fall exactly 2+LOCK_STABLE_CYC+RST_HOLD_CYC edges after the first edge that samples pll_lock high.

Reset
REQ-013 While reset=1, all outputs SHALL take these values immediately, without a clock:
- state=PLL_RST, cnt=0, synchronizer=0.
- pll_reset=1, sys_rst=1, locked=0.
- retry_cnt=0, lost_cnt=0.
REQ-014 Reset asserted in any state SHALL restart the full sequence from PLL_RST. PLL_RST lasts PLL_RST_CYC cycles after reset deasserts.

Configuration
REQ-015 Macro PLL_RST_SEQ_RETRY_EN.
- Defined: REQ-006 timeout and retry apply.
- Undefined: WAIT_LOCK waits for lock indefinitely, no timeout logic is built, and retry_cnt is tied to 0.

Verification
All scenarios use PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, RST_HOLD_CYC=4, with PLL_RST_SEQ_RETRY_EN defined unless stated.
REQ-016 Release reset; raise pll_lock at cycle 10 -> pll_reset falls after 4 cycles, sys_rst falls 14 edges after lock is sampled, locked=1, state=4.
REQ-017 Keep pll_lock low -> pll_reset pulses 4 cycles every 36 cycles; retry_cnt reads 1, 2, 3, ... and saturates at 255 after long run.
REQ-018 In STABLE, drop pll_lock for 1 cycle at cnt=5 -> return to WAIT_LOCK; the later full 8-cycle stable window is needed before HOLD; retry_cnt unchanged.
REQ-019 In RUN, drop pll_lock -> sys_rst=1, locked=0, pll_reset=1 three edges later; lost_cnt=1; relock repeats REQ-016 timing.
REQ-020 Assert reset asynchronously mid-HOLD -> outputs match REQ-013 before the next clkin edge.
REQ-021 With PLL_RST_SEQ_RETRY_EN undefined and pll_lock low for 1000 cycles -> pll_reset stays 0 after the initial pulse, state=1, retry_cnt=0.
